mem_arbiter: RTL

Single-port memory responder sitting below the pipeline: it serves the instruction-fetch requester (iREN) and the EX/MEM-stage data requester (dREN/dWEN), arbitrates both onto one RAM port, and returns one-cycle ihit/dhit pulses with registered load data. It is the responding end of the dREN/dWEN → dhit handshake driven by the pipeline's memory stage, and of the iREN → ihit handshake that gates pipeline advance.

---
 rtl/cpu_types_pkg.sv | 26 ++
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: bus words, RAM handshake states,
// memory access kinds and arbiter FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [1:0] {
    IREAD,
    DREAD,
    DWRITE
  } access_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_RESP
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Port bundle for mem_arbiter: pipeline/cache side
// requests and the single RAM port.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic  iREN;
  word_t iaddr;
  logic  ihit;
  word_t iload;
  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  logic  dhit;
  word_t dload;
  logic  memerr;
  logic  ramREN;
  logic  ramWEN;
  word_t ramaddr;
  word_t ramstore;
  word_t ramload;
  logic [1:0] ramstate;

  modport cpu (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  ihit, iload, dhit, dload, memerr
  );

  modport ram (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM responder arbitrating instruction fetch
// and data accesses; data always wins.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_t    state_q, state_d;
  access_t       kind_q, kind_d;
  word_t         addr_q, addr_d;
  word_t         data_q, data_d;
  word_t         iload_q, iload_d;
  word_t         dload_q, dload_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  ramstate_t     rs;
  logic [CW-1:0] cnt_inc;
  logic          timeout;

  assign rs      = ramstate_t'(ramstate);
  assign cnt_inc = cnt_q + 1'b1;
  assign timeout = (cnt_inc == CW'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    addr_d  = addr_q;
    data_d  = data_q;
    iload_d = iload_q;
    dload_d = dload_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ARB_IDLE: begin
        cnt_d = '0;
        if (dREN || dWEN) begin
          state_d = ARB_ACCESS;
          kind_d  = dWEN ? DWRITE : DREAD;
          addr_d  = daddr;
          data_d  = dstore;
          if (dREN && dWEN) err_d = 1'b1;
        end else if (iREN) begin
          state_d = ARB_ACCESS;
          kind_d  = IREAD;
          addr_d  = iaddr;
        end
      end
      ARB_ACCESS: begin
        cnt_d = cnt_inc;
        if (rs == ACCESS) begin
          state_d = ARB_RESP;
          if (kind_q == IREAD) iload_d = ramload;
          if (kind_q == DREAD) dload_d = ramload;
        end else if (rs == ERROR || timeout) begin
          // abandoned; a still-held request is retried from IDLE
          state_d = ARB_IDLE;
          err_d   = 1'b1;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ARB_IDLE;
      kind_q  <= IREAD;
      addr_q  <= '0;
      data_q  <= '0;
      iload_q <= '0;
      dload_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // hit is suppressed when the requester has withdrawn
  assign ihit = (state_q == ARB_RESP) && (kind_q == IREAD)
              && iREN;
  assign dhit = (state_q == ARB_RESP) && (kind_q != IREAD)
              && (dREN || dWEN);

  assign ramREN   = (state_q == ARB_ACCESS) && (kind_q != DWRITE);
  assign ramWEN   = (state_q == ARB_ACCESS) && (kind_q == DWRITE);
  assign ramaddr  = (state_q == ARB_ACCESS) ? addr_q : '0;
  assign ramstore = ramWEN ? data_q : '0;

  assign iload  = iload_q;
  assign dload  = dload_q;
  assign memerr = err_q;

endmodule
